// File: rtl/approx_sweep_pkg.sv
// Shared types and width helpers for the approximate-circuit error sweeper.
// The early-abort option is selected with APPROX_SWEEP_EARLY_ABORT_EN.
package approx_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } sweep_state_e;

    function automatic int cnt_width(input int n_in);
        return n_in + 1;
    endfunction

    function automatic int sum_width(input int n_out, input int n_in);
        return n_out + n_in;
    endfunction

    function automatic int last_vec(input int n_in);
        return (1 << n_in) - 1;
    endfunction

    localparam int DEFAULT_N_IN = 4;
    localparam int LAST_VEC     = last_vec(DEFAULT_N_IN);

endpackage

// File: rtl/approx_abs_diff.sv
// Unsigned absolute difference of two circuit outputs, with a flag for
// differences strictly above the error threshold.
module approx_abs_diff #(
    parameter int N_OUT = 3,
    parameter int ET    = 0
) (
    input  logic [N_OUT-1:0] a,
    input  logic [N_OUT-1:0] b,
    output logic [N_OUT-1:0] diff,
    output logic             gt_et
);

    always_comb begin
        diff  = (a >= b) ? (a - b) : (b - a);
        gt_et = int'(diff) > ET;
    end

endmodule

// File: rtl/approx_error_sweeper.sv
// Sweeps all input vectors of a circuit pair and accumulates error statistics.
// Define APPROX_SWEEP_EARLY_ABORT_EN to stop at the first vector above ET.
module approx_error_sweeper
    import approx_sweep_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 3,
    parameter int ET    = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [N_IN-1:0]        vec_o,
    input  logic [N_OUT-1:0]       exact_i,
    input  logic [N_OUT-1:0]       approx_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [N_OUT-1:0]       max_err_o,
    output logic [N_IN:0]          err_cnt_o,
    output logic [N_OUT+N_IN-1:0]  sum_err_o,
    output logic                   pass_o,
    output logic [N_IN-1:0]        fail_vec_o
);

    localparam int CNT_W = cnt_width(N_IN);
    localparam int SUM_W = sum_width(N_OUT, N_IN);
    localparam logic [N_IN-1:0]  LAST    = N_IN'(last_vec(N_IN));
    localparam logic [N_IN-1:0]  VEC_ONE = N_IN'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    sweep_state_e      state_q, state_d;
    logic [N_IN-1:0]   vec_q;
    logic [N_OUT-1:0]  max_q, max_next;
    logic [CNT_W-1:0]  cnt_q;
    logic [SUM_W-1:0]  sum_q;
    logic [N_IN-1:0]   fail_vec_q;
    logic              fail_seen_q;
    logic              pass_q;
    logic [N_OUT-1:0]  diff;
    logic              gt_et;

    approx_abs_diff #(.N_OUT(N_OUT), .ET(ET)) u_abs_diff (
        .a     (exact_i),
        .b     (approx_i),
        .diff  (diff),
        .gt_et (gt_et)
    );

    always_comb begin
        state_d  = state_q;
        max_next = (diff > max_q) ? diff : max_q;
        case (state_q)
            IDLE:  if (start) state_d = SWEEP;
            SWEEP: begin
                if (vec_q == LAST) state_d = DONE;
`ifdef APPROX_SWEEP_EARLY_ABORT_EN
                if (gt_et) state_d = DONE;
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pass is resolved on entry to DONE so it is already valid alongside done_o.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            max_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            fail_vec_q  <= '0;
            fail_seen_q <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        vec_q       <= '0;
                        max_q       <= '0;
                        cnt_q       <= '0;
                        sum_q       <= '0;
                        fail_vec_q  <= '0;
                        fail_seen_q <= 1'b0;
                        pass_q      <= 1'b0;
                    end
                end
                SWEEP: begin
                    max_q <= max_next;
                    if (diff != '0) cnt_q <= cnt_q + CNT_ONE;
                    sum_q <= sum_q + {{(SUM_W-N_OUT){1'b0}}, diff};
                    if (gt_et && !fail_seen_q) begin
                        fail_vec_q  <= vec_q;
                        fail_seen_q <= 1'b1;
                    end
                    if (state_d == SWEEP) vec_q <= vec_q + VEC_ONE;
                    else pass_q <= !(int'(max_next) > ET);
                end
                default: ;
            endcase
        end
    end

    assign vec_o      = vec_q;
    assign busy_o     = (state_q == SWEEP);
    assign done_o     = (state_q == DONE);
    assign max_err_o  = max_q;
    assign err_cnt_o  = cnt_q;
    assign sum_err_o  = sum_q;
    assign pass_o     = pass_q;
    assign fail_vec_o = fail_vec_q;

endmodule

// File: tb/tb_approx_error_sweeper.sv
// Self-checking bench: two sweepers (ET=0 and ET=1) evaluate the same
// circuit pair, described as lookup tables indexed by each sweeper's vector.
module tb_approx_error_sweeper;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;

    logic [2:0] exact_tab  [16];
    logic [2:0] approx_tab [16];

    logic [3:0] vec0, vec1, fv0, fv1;
    logic [2:0] ex0, ex1, ap0, ap1, mx0, mx1;
    logic       busy0, busy1, done0, done1, pass0, pass1;
    logic [4:0] cnt0, cnt1;
    logic [6:0] sum0, sum1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ex0 = exact_tab[vec0];
    assign ap0 = approx_tab[vec0];
    assign ex1 = exact_tab[vec1];
    assign ap1 = approx_tab[vec1];

    approx_error_sweeper #(.N_IN(4), .N_OUT(3), .ET(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .vec_o(vec0),
        .exact_i(ex0), .approx_i(ap0), .busy_o(busy0), .done_o(done0),
        .max_err_o(mx0), .err_cnt_o(cnt0), .sum_err_o(sum0),
        .pass_o(pass0), .fail_vec_o(fv0)
    );

    approx_error_sweeper #(.N_IN(4), .N_OUT(3), .ET(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .vec_o(vec1),
        .exact_i(ex1), .approx_i(ap1), .busy_o(busy1), .done_o(done1),
        .max_err_o(mx1), .err_cnt_o(cnt1), .sum_err_o(sum1),
        .pass_o(pass1), .fail_vec_o(fv1)
    );

    typedef struct {
        int mx, cnt, sum, ps, fv, nev;
    } exp_t;

    typedef struct {
        int   mode;
        exp_t e0;
        exp_t e1;
    } vector_t;

    vector_t tbl[3];

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Circuit pairs: 0 identical, 1 two-bit adder vs constant 0, 2 LSB flip, 3 random
    task automatic fill_tables(input int mode);
        for (int v = 0; v < 16; v++) begin
            case (mode)
                0: begin exact_tab[v] = 3'(v & 7); approx_tab[v] = 3'(v & 7); end
                1: begin exact_tab[v] = 3'((v & 3) + ((v >> 2) & 3)); approx_tab[v] = 3'd0; end
                2: begin exact_tab[v] = 3'(v & 7); approx_tab[v] = 3'(v & 7) ^ 3'b001; end
                default: begin
                    exact_tab[v]  = 3'($urandom_range(0, 7));
                    approx_tab[v] = 3'($urandom_range(0, 7));
                end
            endcase
        end
    endtask

    // Reference: walk the vector list and accumulate |exact-approx| directly
    task automatic model(input int et, output exp_t e);
        bit seen;
        seen = 0;
        e = '{0, 0, 0, 0, 0, 0};
        for (int v = 0; v < 16; v++) begin
            int d;
            d = int'(exact_tab[v]) - int'(approx_tab[v]);
            if (d < 0) d = -d;
            e.nev++;
            if (d > e.mx) e.mx = d;
            if (d != 0) e.cnt++;
            e.sum += d;
            if (d > et && !seen) begin
                seen = 1;
                e.fv = v;
`ifdef APPROX_SWEEP_EARLY_ABORT_EN
                break;
`endif
            end
        end
        e.ps = (e.mx <= et) ? 1 : 0;
    endtask

    task automatic check_results(input string tag, input int which, input exp_t e,
                                 input int dcyc, input int dcnt, input int bcnt);
        if (which == 0) begin
            check_output({tag, " dut0 done_cycle"}, dcyc, e.nev + 1);
            check_output({tag, " dut0 done_pulses"}, dcnt, 1);
            check_output({tag, " dut0 busy_cycles"}, bcnt, e.nev);
            check_output({tag, " dut0 max_err"}, int'(mx0), e.mx);
            check_output({tag, " dut0 err_cnt"}, int'(cnt0), e.cnt);
            check_output({tag, " dut0 sum_err"}, int'(sum0), e.sum);
            check_output({tag, " dut0 pass"}, int'(pass0), e.ps);
            check_output({tag, " dut0 fail_vec"}, int'(fv0), e.fv);
        end else begin
            check_output({tag, " dut1 done_cycle"}, dcyc, e.nev + 1);
            check_output({tag, " dut1 done_pulses"}, dcnt, 1);
            check_output({tag, " dut1 busy_cycles"}, bcnt, e.nev);
            check_output({tag, " dut1 max_err"}, int'(mx1), e.mx);
            check_output({tag, " dut1 err_cnt"}, int'(cnt1), e.cnt);
            check_output({tag, " dut1 sum_err"}, int'(sum1), e.sum);
            check_output({tag, " dut1 pass"}, int'(pass1), e.ps);
            check_output({tag, " dut1 fail_vec"}, int'(fv1), e.fv);
        end
    endtask

    // Pulse start in cycle 0 (called at a negedge) and observe until both sweepers are done
    task automatic apply_stimulus(output int d0, output int d1, output int n0, output int n1,
                                  output int b0, output int b1);
        d0 = -1; d1 = -1; n0 = 0; n1 = 0; b0 = 0; b1 = 0;
        start = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy0) b0++;
            if (busy1) b1++;
            if (done0) begin n0++; if (d0 < 0) d0 = c; end
            if (done1) begin n1++; if (d1 < 0) d1 = c; end
            if (d0 >= 0 && d1 >= 0 && c >= d0 + 2 && c >= d1 + 2) break;
        end
    endtask

    task automatic run_and_check(input string tag, input exp_t e0, input exp_t e1);
        int d0, d1, n0, n1, b0, b1;
        apply_stimulus(d0, d1, n0, n1, b0, b1);
        check_results(tag, 0, e0, d0, n0, b0);
        check_results(tag, 1, e1, d1, n1, b1);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, " busy"}, int'(busy0) + int'(busy1), 0);
        check_output({tag, " done"}, int'(done0) + int'(done1), 0);
        check_output({tag, " vec"}, int'(vec0) + int'(vec1), 0);
        check_output({tag, " max_err"}, int'(mx0) + int'(mx1), 0);
        check_output({tag, " err_cnt"}, int'(cnt0) + int'(cnt1), 0);
        check_output({tag, " sum_err"}, int'(sum0) + int'(sum1), 0);
        check_output({tag, " pass"}, int'(pass0) + int'(pass1), 0);
        check_output({tag, " fail_vec"}, int'(fv0) + int'(fv1), 0);
    endtask

    initial begin
        exp_t r0, r1;
        int   c5, first_done, second_done, ndone, ndone1;

        // Expected results for the three directed circuit pairs: {mx,cnt,sum,pass,fail_vec,vectors}
        tbl[0] = '{0, '{0, 0, 0, 1, 0, 16}, '{0, 0, 0, 1, 0, 16}};
`ifndef APPROX_SWEEP_EARLY_ABORT_EN
        tbl[1] = '{1, '{6, 15, 48, 0, 1, 16}, '{6, 15, 48, 0, 2, 16}};
        tbl[2] = '{2, '{1, 16, 16, 0, 0, 16}, '{1, 16, 16, 1, 0, 16}};
`else
        tbl[1] = '{1, '{1, 1, 1, 0, 1, 2}, '{2, 2, 3, 0, 2, 3}};
        tbl[2] = '{2, '{1, 1, 1, 0, 0, 1}, '{1, 16, 16, 1, 0, 16}};
`endif

        fill_tables(0);
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            fill_tables(tbl[i].mode);
            run_and_check($sformatf("table%0d", i), tbl[i].e0, tbl[i].e1);
        end

        // Reset in the middle of a sweep, then a clean full sweep
        fill_tables(0);
        start = 1'b1;
        c5 = -1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy0 && vec0 == 4'd5) begin c5 = c; break; end
        end
        check_output("midreset vec5 cycle", c5, 6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("midreset");
        @(negedge clk);
        check_output("midreset idle done", int'(done0) + int'(done1), 0);
        fill_tables(2);
        run_and_check("after_reset", tbl[2].e0, tbl[2].e1);

        // start pulses while busy (cycle 3) and in DONE (cycle 17) are ignored; cycle 18 is accepted
        fill_tables(0);
        first_done = -1; second_done = -1; ndone = 0; ndone1 = 0;
        start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = (c == 3 || c == 17 || c == 18);
            if (done0) begin
                ndone++;
                if (first_done < 0) first_done = c;
                else if (second_done < 0) second_done = c;
            end
            if (done1) ndone1++;
        end
        start = 1'b0;
        check_output("ignore first done", first_done, 17);
        check_output("ignore second done", second_done, 35);
        check_output("ignore done count dut0", ndone, 2);
        check_output("ignore done count dut1", ndone1, 2);
        @(negedge clk);

        // Random circuit pairs against the reference model
        for (int k = 0; k < 6; k++) begin
            fill_tables(3);
            model(0, r0);
            model(1, r1);
            run_and_check($sformatf("random%0d", k), r0, r1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
